// File: rtl/btn_pkg.sv
// Shared button definitions: board bit order and the per-channel repeat states.
package btn_pkg;

    localparam int BTN_UP     = 0;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 2;
    localparam int BTN_DOWN   = 3;
    localparam int BTN_CENTRE = 4;
    localparam int BTN_N      = 5;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: two-flop synchroniser, stable-time debounce, edge pulses and
// an auto-repeat step generator.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYC      = 20000,
    parameter int REPEAT_DELAY_CYC  = 500000,
    parameter int REPEAT_PERIOD_CYC = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic btn_level,
    output logic press,
    output logic btn_release,
    output logic step
);

    localparam int CNT_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int TMR_RAW = $clog2(max_int(REPEAT_DELAY_CYC, REPEAT_PERIOD_CYC));
    localparam int TMR_W   = (TMR_RAW < 1) ? 1 : TMR_RAW;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD_CYC - 1);

    logic             sync_meta;
    logic             s;
    logic [CNT_W-1:0] cnt;
    logic [TMR_W-1:0] tmr;
    rpt_state_t       state;
    logic             flip;
    logic             rise;
    logic             fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            s         <= 1'b0;
        end else begin
            sync_meta <= btn;
            s         <= sync_meta;
        end
    end

    // Level flips only after the synchronised input has disagreed with it
    // for DEBOUNCE_CYC consecutive cycles; any agreement restarts the count.
    assign flip = (s != btn_level) && (cnt == CNT_LAST);
    assign rise = flip && s;
    assign fall = flip && !s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_level <= 1'b0;
            cnt       <= '0;
        end else if (s == btn_level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            btn_level <= s;
            cnt       <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press       <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            press       <= rise;
            btn_release <= fall;
        end
    end

    // A falling level wins over any repeat that would land in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RPT_IDLE;
            tmr   <= '0;
            step  <= 1'b0;
        end else begin
            step <= 1'b0;
            if (fall) begin
                state <= RPT_IDLE;
                tmr   <= '0;
            end else begin
                case (state)
                    RPT_IDLE: begin
                        if (rise) begin
                            step  <= 1'b1;
                            tmr   <= '0;
                            state <= RPT_DELAY;
                        end
                    end
                    RPT_DELAY: begin
                        if (tmr == DELAY_LAST) begin
                            step  <= 1'b1;
                            tmr   <= '0;
                            state <= RPT_REPEAT;
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                    RPT_REPEAT: begin
                        if (tmr == PERIOD_LAST) begin
                            step <= 1'b1;
                            tmr  <= '0;
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                    default: begin
                        state <= RPT_IDLE;
                        tmr   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/btn_debounce_repeat.sv
// Button conditioning for the board: N_BTN independent debounce/repeat channels.
// The release pulse output is btn_release because "release" is a reserved word.
module btn_debounce_repeat
    import btn_pkg::*;
#(
    parameter int N_BTN             = BTN_N,
    parameter int DEBOUNCE_CYC      = 20000,
    parameter int REPEAT_DELAY_CYC  = 500000,
    parameter int REPEAT_PERIOD_CYC = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] step
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYC      (DEBOUNCE_CYC),
            .REPEAT_DELAY_CYC  (REPEAT_DELAY_CYC),
            .REPEAT_PERIOD_CYC (REPEAT_PERIOD_CYC)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .btn         (btn[i]),
            .btn_level   (btn_level[i]),
            .press       (press[i]),
            .btn_release (btn_release[i]),
            .step        (step[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce_repeat.sv
// Scoreboard bench for btn_debounce_repeat: a window-based debounce model and
// arithmetic repeat schedule predict every cycle's outputs.
module tb_btn_debounce_repeat;

    localparam int NB = 5;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    typedef struct packed {
        int          edge_no;
        logic [NB-1:0] lvl;
        logic [NB-1:0] prs;
        logic [NB-1:0] rls;
        logic [NB-1:0] stp;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [NB-1:0] btn;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] step;

    int checks = 0;
    int errors = 0;

    exp_t          sb[$];
    int            edge_cnt;
    logic [NB-1:0] model_lvl;
    int            press_edge[NB];
    logic [NB-1:0] samp[0:4095];

    btn_debounce_repeat #(
        .N_BTN             (NB),
        .DEBOUNCE_CYC      (DB),
        .REPEAT_DELAY_CYC  (RD),
        .REPEAT_PERIOD_CYC (RP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn         (btn),
        .btn_level   (btn_level),
        .press       (press),
        .btn_release (btn_release),
        .step        (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int edge_no,
                               input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s edge %0d: got %b expected %b", name, edge_no, act, exp);
        end
    endtask

    task automatic modelReset();
        edge_cnt  = 0;
        model_lvl = '0;
        for (int i = 0; i < NB; i++) press_edge[i] = 0;
    endtask

    // Level toggles once the last DB synchronised samples (raw samples two
    // edges old) all disagree with it; steps follow a fixed schedule from the press.
    task automatic modelEdge(input logic [NB-1:0] b);
        exp_t e;
        logic diff;
        logic v;
        logic new_l;
        edge_cnt++;
        if (edge_cnt < 4096) samp[edge_cnt] = b;
        e.edge_no = edge_cnt;
        for (int i = 0; i < NB; i++) begin
            diff = 1'b1;
            for (int j = edge_cnt - DB - 1; j <= edge_cnt - 2; j++) begin
                v = (j >= 1 && j < 4096) ? samp[j][i] : 1'b0;
                if (v == model_lvl[i]) diff = 1'b0;
            end
            new_l    = diff ? ~model_lvl[i] : model_lvl[i];
            e.prs[i] = new_l & ~model_lvl[i];
            e.rls[i] = ~new_l & model_lvl[i];
            if (e.prs[i]) press_edge[i] = edge_cnt;
            e.stp[i] = new_l && ((edge_cnt == press_edge[i]) ||
                       ((edge_cnt >= press_edge[i] + RD) &&
                        ((edge_cnt - press_edge[i] - RD) % RP == 0)));
            e.lvl[i] = new_l;
        end
        model_lvl = e.lvl;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic [NB-1:0] value, input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            btn = value;
            modelEdge(value);
        end
    endtask

    task automatic pushZero();
        exp_t z;
        z = '0;
        z.edge_no = -1;
        sb.push_back(z);
    endtask

    // Reset asserted halfway between edges; outputs must drop without a clock.
    task automatic resetPulse(input logic [NB-1:0] value);
        @(negedge clk);
        btn = value;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_level", -1, btn_level, '0);
        checkOutput("async_press", -1, press, '0);
        checkOutput("async_release", -1, btn_release, '0);
        checkOutput("async_step", -1, step, '0);
        repeat (2) begin
            @(negedge clk);
            pushZero();
        end
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        modelEdge(value);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("btn_level", e.edge_no, btn_level, e.lvl);
                checkOutput("press", e.edge_no, press, e.prs);
                checkOutput("release", e.edge_no, btn_release, e.rls);
                checkOutput("step", e.edge_no, step, e.stp);
            end
        end
    end

    initial begin : driver
        int            hold_left[NB];
        logic [NB-1:0] cur;

        rst_n = 1'b1;
        btn   = 5'b11111;
        modelReset();
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_level", 0, btn_level, '0);
        checkOutput("reset_step", 0, step, '0);
        repeat (3) begin
            @(negedge clk);
            pushZero();
        end
        @(negedge clk);
        rst_n = 1'b1;
        modelEdge(5'b11111);
        applyStimulus(5'b11111, 9);
        applyStimulus(5'b00000, 12);

        // Clean hold through several repeats, then release.
        applyStimulus(5'b00001, 24);
        applyStimulus(5'b00000, 12);

        // Bounce on down: never stable long enough.
        repeat (5) begin
            applyStimulus(5'b01000, 3);
            applyStimulus(5'b00000, 1);
        end
        applyStimulus(5'b00000, 10);

        // Release landing on a repeat slot.
        applyStimulus(5'b00001, 19);
        applyStimulus(5'b00000, 12);

        // Simultaneous left + right.
        applyStimulus(5'b00110, 30);
        applyStimulus(5'b00000, 10);

        // Reset while repeating, button kept held.
        applyStimulus(5'b00001, 17);
        resetPulse(5'b00001);
        applyStimulus(5'b00001, 25);
        applyStimulus(5'b00000, 10);

        // Randomised per-button hold lengths, mixing bounces and long holds.
        cur = '0;
        for (int i = 0; i < NB; i++) hold_left[i] = int'($urandom_range(1, 30));
        repeat (400) begin
            for (int i = 0; i < NB; i++) begin
                hold_left[i]--;
                if (hold_left[i] <= 0) begin
                    cur[i]       = ~cur[i];
                    hold_left[i] = int'($urandom_range(1, 30));
                end
            end
            applyStimulus(cur, 1);
        end
        applyStimulus(5'b00000, 12);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_debounce_repeat.md
Name: btn_debounce_repeat

Overview:
Button conditioning stage upstream of the board counter/display logic. It replaces the free-running latch-tick sampling of the raw push-buttons.
- Synchronises each raw button and debounces it with a per-button stable-time counter.
- Emits single-cycle press/release pulses and a "step" pulse that auto-repeats while a button is held.
- Downstream logic runs on clk and consumes step/press as synchronous enables, never as clocks.

Parameters:
- N_BTN, 5, number of buttons. Bit order: 0 up, 1 left, 2 right, 3 down, 4 centre.
- DEBOUNCE_CYC, 20000, consecutive clk cycles a synchronised input must differ from the debounced level before the level flips. Must be >= 1.
- REPEAT_DELAY_CYC, 500000, clk cycles from the press step to the first repeat step. Must be >= 1.
- REPEAT_PERIOD_CYC, 100000, clk cycles between subsequent repeat steps. Must be >= 1.

Ports:
- clk  input  1  system clock; the only clock.
- rst_n  input  1  reset, asynchronous, active-low.
- btn  input  N_BTN  raw, asynchronous, bouncing button inputs, active-high.
- btn_level  output  N_BTN  debounced button level, registered.
- press  output  N_BTN  one-cycle pulse on each debounced rising edge.
- release  output  N_BTN  one-cycle pulse on each debounced falling edge.
- step  output  N_BTN  one-cycle pulse on press, then on every auto-repeat.

Behaviour:
- Reset (async, rst_n=0):
  - Synchroniser flops, debounced levels, counters, timers and all outputs go to 0.
  - Every channel goes to IDLE.
  - Outputs go low immediately, not at the next clk edge.
- Synchroniser: two flops per bit, reset to 0. Call the output s.
- Debounce, per bit, with counter cnt of width $clog2(DEBOUNCE_CYC+1):
  - If s == btn_level: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYC-1: btn_level <= s and cnt <= 0.
  - Else: cnt <= cnt+1.
  - cnt never wraps. Any bounce back to the current level clears cnt.
- Latency: number clk edges from 1 at the first edge that samples the new raw value (input held steady). btn_level updates at edge 2+DEBOUNCE_CYC. Any raw pulse shorter than DEBOUNCE_CYC cycles produces no output.
- Press/release:
  - press[i] is high for exactly the one cycle after the edge where btn_level[i] goes 0->1.
  - release[i] is likewise high for one cycle on a 1->0 transition.
  - Both are registered outputs.
- Repeat FSM, per bit, with states IDLE, DELAY, REPEAT and timer tmr of width $clog2(max(REPEAT_DELAY_CYC, REPEAT_PERIOD_CYC)):
  - IDLE: on a level rise, step=1, tmr<=0, go to DELAY.
  - DELAY: if tmr == REPEAT_DELAY_CYC-1, step=1, tmr<=0, go to REPEAT. Else tmr++.
  - REPEAT: if tmr == REPEAT_PERIOD_CYC-1, step=1, tmr<=0. Else tmr++.
  - Any state: on a level fall, go to IDLE, tmr<=0, step=0 that cycle. Release takes priority over a coinciding repeat.
- step timing: step is registered and aligned with press on the first pulse. With the press step at edge E, repeats occur at E+REPEAT_DELAY_CYC, then every REPEAT_PERIOD_CYC.
- Channel independence:
  - Channels are fully independent. Simultaneous presses on several bits pulse in the same cycle.
  - No priority or one-hot enforcement; the consumer decodes.
- Reset mid-operation:
  - Everything clears.
  - A button held through reset deassertion reappears as a new press at edge 2+DEBOUNCE_CYC after the first clk edge with rst_n=1.
- No combinational path from btn to any output.

Decomposition:
- Shared package btn_pkg holds:
  - Button index constants BTN_UP=0, BTN_LEFT=1, BTN_RIGHT=2, BTN_DOWN=3, BTN_CENTRE=4, BTN_N=5.
  - The repeat state enum rpt_state_t {RPT_IDLE, RPT_DELAY, RPT_REPEAT}.
- One sub-module, btn_channel: synchroniser, debounce counter and repeat FSM for a single bit, with the same parameters.
- btn_debounce_repeat is a generate loop of N_BTN btn_channel instances.

Test Plan:
All scenarios use parameters DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=10, REPEAT_PERIOD_CYC=3.
- Reset: btn=5'b11111 during rst_n=0 -> all outputs 0, including mid-cycle assertion; after rst_n=1, btn_level=5'b11111 and press=5'b11111 at edge 6.
- Clean hold: btn[0] 0->1 and held (edge 1 samples) -> btn_level[0]=1, press[0]=1 and step[0]=1 at edge 6; further step[0] pulses at edges 16, 19, 22; press[0] single cycle only.
- Bounce: btn[3] toggled 1 for 3 cycles, 0 for 1 cycle, repeated 5 times, then 0 -> btn_level/press/step[3] never assert.
- Release: btn[0] held 13 edges past the press step, then 0 -> release[0] pulse 6 edges later, no step after the fall, FSM IDLE; a coinciding repeat is suppressed.
- Simultaneous: btn[1] and btn[2] rise at the same edge -> press[1] and press[2] assert in the same cycle, and step repeats stay phase-aligned.
- Reset mid-repeat: rst_n pulsed low at edge 18 with btn[0] held -> outputs 0 asynchronously; after release, press[0] again 6 edges after the first clk edge with rst_n=1, repeats restart from DELAY.
